regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the RV32I core. It generalises the existing 2-read/1-write regfile in data width, depth and read-port count. It adds an optional same-cycle write-to-read bypass and a per-register pending scoreboard, which lets multi-cycle units (load, mul/div) mark a destination as in flight. It sits between decode (read ports, scoreboard set) and writeback (write port, scoreboard clear).

---
 rtl/regfile_mp_if.sv | 25 ++
 rtl/regfile_mp.sv | 58 +++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bundle between decode, writeback and the register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rs_addr;
    logic [NUM_RD*DATA_W-1:0] rs_data;
    logic [NUM_RD-1:0]        rs_busy;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_wren;
    logic [DATA_W-1:0]        rd_data;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     any_busy;
    logic [ADDR_W:0]          busy_cnt;
    modport master (
        output rs_addr, rd_addr, rd_wren, rd_data, sb_set, sb_addr,
        input  rs_data, rs_busy, any_busy, busy_cnt
    );
    modport slave (
        input  rs_addr, rd_addr, rd_wren, rd_data, sb_set, sb_addr,
        output rs_data, rs_busy, any_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with optional write bypass and pending scoreboard
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         pending;
    logic [DEPTH-1:0]         pending_nxt;
    logic [ADDR_W:0]          busy_q;
    logic                     inc;
    logic                     dec;
    logic [ADDR_W-1:0]        ra [NUM_RD];
    logic [NUM_RD-1:0]        fwd;
    logic [NUM_RD*DATA_W-1:0] rs_data_c;
    logic [NUM_RD-1:0]        rs_busy_c;
    always_comb begin
        pending_nxt = pending;
        if (bus.rd_wren) pending_nxt[bus.rd_addr] = 1'b0;
        // set is applied last so a newer issue wins over a same-cycle writeback
        if (bus.sb_set) pending_nxt[bus.sb_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
        inc = bus.sb_set && (bus.sb_addr != '0) && !pending[bus.sb_addr];
        dec = bus.rd_wren && pending[bus.rd_addr] && !(bus.sb_set && bus.sb_addr == bus.rd_addr);
    end
    always_comb begin
        rs_data_c = '0;
        rs_busy_c = '0;
        fwd       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra[i]  = bus.rs_addr[i*ADDR_W +: ADDR_W];
            fwd[i] = (BYPASS != 0) && bus.rd_wren && (bus.rd_addr == ra[i]) && (ra[i] != '0);
            rs_data_c[i*DATA_W +: DATA_W] = (rst || ra[i] == '0) ? '0 : fwd[i] ? bus.rd_data : mem[ra[i]];
            rs_busy_c[i] = !rst && pending[ra[i]] && !fwd[i];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
            pending <= '0;
            busy_q  <= '0;
        end else begin
            if (bus.rd_wren && bus.rd_addr != '0) mem[bus.rd_addr] <= bus.rd_data;
            pending <= pending_nxt;
            busy_q  <= busy_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end
    assign bus.rs_data  = rs_data_c;
    assign bus.rs_busy  = rs_busy_c;
    assign bus.busy_cnt = busy_q;
    assign bus.any_busy = (busy_q != '0);
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp with bypass on and off
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    assign bus0.rs_addr = bus.rs_addr;
    assign bus0.rd_addr = bus.rd_addr;
    assign bus0.rd_wren = bus.rd_wren;
    assign bus0.rd_data = bus.rd_data;
    assign bus0.sb_set  = bus.sb_set;
    assign bus0.sb_addr = bus.sb_addr;
    always #5 clk = ~clk;
    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];
    task automatic want(input string tag, input logic [63:0] v);
        sb.push_back('{tag, v});
    endtask
    task automatic got(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.rd_wren = 1'b0;
        bus.sb_set  = 1'b0;
    endtask
    task automatic rs(input logic [4:0] a0, input logic [4:0] a1);
        bus.rs_addr = {a1, a0};
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.rd_wren = 1'b1;
        bus.rd_addr = a;
        bus.rd_data = d;
    endtask
    task automatic set(input logic [4:0] a);
        bus.sb_set  = 1'b1;
        bus.sb_addr = a;
    endtask
    task automatic chk_clear(input string tag);
        want({tag, "_data"}, 64'h0);     got(bus.rs_data);
        want({tag, "_busy"}, 64'h0);     got(64'(bus.rs_busy));
        want({tag, "_cnt"}, 64'h0);      got(64'(bus.busy_cnt));
        want({tag, "_any"}, 64'h0);      got(64'(bus.any_busy));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        idle();
        bus.rd_addr = '0;
        bus.rd_data = '0;
        bus.sb_addr = '0;
        rs(5'd0, 5'd1);
        #12;
        chk_clear("reset");
        rst = 1'b0;
        tick();
        wr(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rs(5'd5, 5'd5);
        #2;
        want("wr_x5", {32'hDEADBEEF, 32'hDEADBEEF}); got(bus.rs_data);
        wr(5'd0, 32'h12345678);
        rs(5'd0, 5'd0);
        #2;
        want("x0_same", 64'h0); got(bus.rs_data);
        tick();
        idle();
        #2;
        want("x0_after", 64'h0); got(bus.rs_data);
        wr(5'd7, 32'hA5A5A5A5);
        rs(5'd5, 5'd7);
        #2;
        want("byp_on", {32'hA5A5A5A5, 32'hDEADBEEF});  got(bus.rs_data);
        want("byp_off", {32'h0, 32'hDEADBEEF});        got(bus0.rs_data);
        tick();
        idle();
        #2;
        want("byp_off_next", {32'hA5A5A5A5, 32'hDEADBEEF}); got(bus0.rs_data);
        set(5'd3);
        rs(5'd3, 5'd5);
        #2;
        want("sb_lat_cnt", 64'h0); got(64'(bus.busy_cnt));
        tick();
        idle();
        #2;
        want("sb_busy", 64'h1); got(64'(bus.rs_busy));
        want("sb_cnt", 64'h1);  got(64'(bus.busy_cnt));
        want("sb_any", 64'h1);  got(64'(bus.any_busy));
        wr(5'd3, 32'h33);
        #2;
        want("clr_fwd_busy", 64'h0);   got(64'(bus.rs_busy));
        want("clr_nofwd_busy", 64'h1); got(64'(bus0.rs_busy));
        tick();
        idle();
        #2;
        want("clr_busy", 64'h0); got(64'(bus.rs_busy));
        want("clr_cnt", 64'h0);  got(64'(bus.busy_cnt));
        want("clr_any", 64'h0);  got(64'(bus.any_busy));
        set(5'd3);
        tick();
        set(5'd3);
        wr(5'd3, 32'h44);
        tick();
        idle();
        #2;
        want("setclr_busy", 64'h1); got(64'(bus.rs_busy));
        want("setclr_cnt", 64'h1);  got(64'(bus.busy_cnt));
        want("setclr_data", {32'hDEADBEEF, 32'h44}); got(bus.rs_data);
        wr(5'd3, 32'h45);
        tick();
        set(5'd0);
        tick();
        idle();
        rs(5'd0, 5'd0);
        #2;
        want("set_x0_cnt", 64'h0);  got(64'(bus.busy_cnt));
        want("set_x0_busy", 64'h0); got(64'(bus.rs_busy));
        for (int r = 1; r < 32; r++) begin
            set(5'(r));
            tick();
        end
        idle();
        #2;
        want("cnt31", 64'd31); got(64'(bus.busy_cnt));
        want("any31", 64'h1);  got(64'(bus.any_busy));
        set(5'd1);
        tick();
        idle();
        #2;
        want("reset_pending", 64'd31); got(64'(bus.busy_cnt));
        set(5'd1);
        wr(5'd1, 32'h11);
        tick();
        idle();
        #2;
        want("setclr31", 64'd31); got(64'(bus.busy_cnt));
        wr(5'd2, 32'h22);
        tick();
        idle();
        #2;
        want("clr_to30", 64'd30); got(64'(bus.busy_cnt));
        set(5'd2);
        wr(5'd5, 32'h5);
        tick();
        idle();
        #2;
        want("net_zero", 64'd30); got(64'(bus.busy_cnt));
        wr(5'd4, 32'h55);
        tick();
        idle();
        rs(5'd4, 5'd9);
        #2;
        want("pre_rst_data", {32'h0, 32'h55}); got(bus.rs_data);
        want("pre_rst_busy", 64'h2);           got(64'(bus.rs_busy));
        wr(5'd4, 32'h66);
        #2;
        rst = 1'b1;
        #1;
        chk_clear("midrst");
        idle();
        #1;
        rst = 1'b0;
        tick();
        #2;
        chk_clear("post_rst");
        wr(5'd4, 32'h77);
        tick();
        idle();
        #2;
        want("post_rst_wr", {32'h0, 32'h77}); got(bus.rs_data);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
